sha256_core_param: RTL and testbench

Parametrised SHA-256 compression engine: successor to the fixed single-block `sha256` core. It processes a stream of 512-bit blocks with a start/ready/done handshake, and chains the running digest internally across blocks of a multi-block message, such as the 640-bit scrypt/block header. Throughput is set by a rounds-per-cycle unroll parameter. It sits between the block formatter and the scrypt/PBKDF2 control logic.

---
 rtl/sha256_core_param.sv | 177 +++++++++++++++++
 tb/tb_sha256_core_param.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_core_param.sv
// sha256_core_param: multi-block SHA-256 compression engine.
// Processes one 512-bit block per start/ready/done handshake and keeps the
// running digest internally so that consecutive blocks of a message chain.
// ROUNDS_PER_CYCLE (1, 2, 4 or 8) sets how many rounds are unrolled per clock.
// Optional feature macro: SHA256_MIDSTATE_EN adds the midstate/mid_sel ports
// so a block can start from an externally supplied chaining value.
module sha256_core_param #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         first,
  input  logic [511:0] block,
`ifdef SHA256_MIDSTATE_EN
  input  logic [255:0] midstate,
  input  logic         mid_sel,
`endif
  output logic         ready,
  output logic         done,
  output logic [255:0] digest
);

  localparam int R = ROUNDS_PER_CYCLE;
  localparam int STEPS = 64 / ROUNDS_PER_CYCLE;
  localparam logic [5:0] LAST_STEP = 6'(STEPS - 1);

  localparam logic [255:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  localparam logic [31:0] K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Reject unsupported unroll factors at elaboration time.
  if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_rounds
    $error("sha256_core_param: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

  state_t state, next_state;

  logic [5:0]   counter;
  logic [31:0]  h_reg [8];
  logic [31:0]  work  [8];
  logic [31:0]  w     [16];
  logic [255:0] chain_src;
  logic         accept;

  logic [31:0]  ext [16 + R];
  logic [31:0]  st  [R + 1][8];

  assign accept = (state == IDLE) && start;

  // State register; reset drops straight back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic and the ready output.
  always_comb begin
    next_state = state;
    ready      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) next_state = ROUND;
      end
      ROUND: begin
        if (counter == LAST_STEP) next_state = FINAL;
      end
      FINAL: begin
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Select the chaining value loaded on accept: IV, current digest or midstate.
  always_comb begin
    chain_src = IV;
    if (!first) chain_src = digest;
`ifdef SHA256_MIDSTATE_EN
    if (mid_sel) chain_src = midstate;
`endif
  end

  // Unrolled rounds: extend the schedule window and chain R compression rounds.
  always_comb begin : round_logic
    logic [31:0] t1, t2;
    logic [5:0]  k_idx;
    t1    = '0;
    t2    = '0;
    k_idx = '0;
    for (int j = 0; j < 16; j++) ext[j] = w[j];
    for (int k = 0; k < R; k++) begin
      ext[16 + k] = small_sigma1(ext[14 + k]) + ext[9 + k] + small_sigma0(ext[1 + k]) + ext[k];
    end
    for (int j = 0; j < 8; j++) st[0][j] = work[j];
    for (int i = 0; i < R; i++) begin
      k_idx = counter * 6'(R) + 6'(i);
      t1 = st[i][7] + big_sigma1(st[i][4])
         + ((st[i][4] & st[i][5]) ^ (~st[i][4] & st[i][6]))
         + K_TABLE[k_idx] + ext[i];
      t2 = big_sigma0(st[i][0])
         + ((st[i][0] & st[i][1]) ^ (st[i][0] & st[i][2]) ^ (st[i][1] & st[i][2]));
      st[i + 1][0] = t1 + t2;
      st[i + 1][1] = st[i][0];
      st[i + 1][2] = st[i][1];
      st[i + 1][3] = st[i][2];
      st[i + 1][4] = st[i][3] + t1;
      st[i + 1][5] = st[i][4];
      st[i + 1][6] = st[i][5];
      st[i + 1][7] = st[i][6];
    end
  end

  // Datapath registers: load on accept, advance per round step, fold on FINAL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter <= '0;
      done    <= 1'b0;
      digest  <= '0;
      for (int j = 0; j < 8; j++) begin
        h_reg[j] <= '0;
        work[j]  <= '0;
      end
      for (int j = 0; j < 16; j++) w[j] <= '0;
    end else begin
      done <= (state == FINAL);
      if (accept) begin
        counter <= '0;
        for (int j = 0; j < 8; j++) begin
          h_reg[j] <= chain_src[255 - 32*j -: 32];
          work[j]  <= chain_src[255 - 32*j -: 32];
        end
        for (int j = 0; j < 16; j++) w[j] <= block[511 - 32*j -: 32];
      end else if (state == ROUND) begin
        counter <= counter + 6'd1;
        for (int j = 0; j < 8; j++)  work[j] <= st[R][j];
        for (int j = 0; j < 16; j++) w[j] <= ext[j + R];
      end else if (state == FINAL) begin
        for (int j = 0; j < 8; j++) digest[255 - 32*j -: 32] <= h_reg[j] + work[j];
      end
    end
  end

endmodule

// File: tb/tb_sha256_core_param.sv
// Testbench for sha256_core_param: directed and random blocks checked
// against a full-schedule SHA-256 compression model held in the bench.
// Build with SHA256_MIDSTATE_EN defined to also exercise the midstate path.
module tb_sha256_core_param;

  localparam logic [255:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DIGEST =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_DIGEST =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic [31:0] kb [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk = 1'b0;
  logic         rst, start, start_x, first;
  logic [511:0] block;
`ifdef SHA256_MIDSTATE_EN
  logic [255:0] midstate;
  logic         mid_sel;
`endif
  logic         ready1, done1, ready2, done2, ready4, done4, ready8, done8;
  logic [255:0] digest1, digest2, digest4, digest8;

  int n_checks = 0;
  int n_fail = 0;
  int busy_cycles;
  logic [255:0] exp_digest;

  always #5 clk = ~clk;

  sha256_core_param #(.ROUNDS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .first(first), .block(block),
`ifdef SHA256_MIDSTATE_EN
    .midstate(midstate), .mid_sel(mid_sel),
`endif
    .ready(ready1), .done(done1), .digest(digest1));

  sha256_core_param #(.ROUNDS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst(rst), .start(start_x), .first(first), .block(block),
`ifdef SHA256_MIDSTATE_EN
    .midstate(midstate), .mid_sel(mid_sel),
`endif
    .ready(ready2), .done(done2), .digest(digest2));

  sha256_core_param #(.ROUNDS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .start(start_x), .first(first), .block(block),
`ifdef SHA256_MIDSTATE_EN
    .midstate(midstate), .mid_sel(mid_sel),
`endif
    .ready(ready4), .done(done4), .digest(digest4));

  sha256_core_param #(.ROUNDS_PER_CYCLE(8)) dut8 (
    .clk(clk), .rst(rst), .start(start_x), .first(first), .block(block),
`ifdef SHA256_MIDSTATE_EN
    .midstate(midstate), .mid_sel(mid_sel),
`endif
    .ready(ready8), .done(done8), .digest(digest8));

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference compression: full 64-word schedule, then 64 rounds, then fold.
  function automatic logic [255:0] refCompress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] wm [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2, s0, s1;
    logic [255:0] res;
    for (int t = 0; t < 16; t++) wm[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rr(wm[t-15], 7) ^ rr(wm[t-15], 18) ^ (wm[t-15] >> 3);
      s1 = rr(wm[t-2], 17) ^ rr(wm[t-2], 19) ^ (wm[t-2] >> 10);
      wm[t] = s1 + wm[t-7] + s0 + wm[t-16];
    end
    for (int j = 0; j < 8; j++) v[j] = hin[255 - 32*j -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + kb[t] + wm[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int j = 0; j < 8; j++) res[255 - 32*j -: 32] = hin[255 - 32*j -: 32] + v[j];
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offer one block to the R=1 engine and wait for the accept edge.
  task automatic applyStimulus(input string tag, input logic f, input logic [511:0] b);
    checkOutput({tag, "_ready"}, 256'(ready1), 256'd1);
    first = f;
    block = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    busy_cycles = (ready1 == 1'b0) ? 1 : 0;
  endtask

  // Count edges until done, bounded; also count cycles with ready low.
  task automatic waitDone(input string tag, output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
      if (!done1 && !ready1) busy_cycles++;
    end while (!done1 && cycles < 200);
    checkOutput({tag, "_done_seen"}, 256'(done1), 256'd1);
  endtask

  task automatic runBlock(input string tag, input logic f, input logic [511:0] b, input logic [255:0] exp);
    int lat;
    applyStimulus(tag, f, b);
    waitDone(tag, lat);
    checkOutput({tag, "_latency"}, 256'(lat), 256'd65);
    checkOutput({tag, "_busy"}, 256'(busy_cycles), 256'd65);
    checkOutput({tag, "_digest"}, digest1, exp);
  endtask

  initial begin : main
    logic [511:0] abc_blk, empty_blk, two_b1, two_b2, rnd_blk;
    logic [255:0] mid1;
    logic         rf;
    int           lat, lat2, lat4, lat8;

    abc_blk   = {32'h61626380, 448'h0, 32'h00000018};
    empty_blk = {32'h80000000, 480'h0};
    two_b1    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    two_b2    = {480'h0, 32'h000001c0};
    mid1      = refCompress(IV, two_b1);

    rst = 1'b1; start = 1'b0; start_x = 1'b0; first = 1'b1; block = '0;
`ifdef SHA256_MIDSTATE_EN
    midstate = '0; mid_sel = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_ready", 256'(ready1), 256'd1);
    checkOutput("reset_done", 256'(done1), 256'd0);
    checkOutput("reset_digest", digest1, 256'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // "abc" single block, then check the done pulse is one cycle wide.
    runBlock("abc", 1'b1, abc_blk, ABC_DIGEST);
    @(posedge clk);
    #1;
    checkOutput("abc_done_pulse", 256'(done1), 256'd0);

    // Empty message on R=1, then on R=2/4/8 in parallel.
    runBlock("empty_r1", 1'b1, empty_blk, EMPTY_DIGEST);
    first = 1'b1; block = empty_blk; start_x = 1'b1;
    @(posedge clk);
    #1;
    start_x = 1'b0;
    lat2 = 0; lat4 = 0; lat8 = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (done2 && lat2 == 0) lat2 = c;
      if (done4 && lat4 == 0) lat4 = c;
      if (done8 && lat8 == 0) lat8 = c;
    end
    checkOutput("empty_r2_latency", 256'(lat2), 256'd33);
    checkOutput("empty_r4_latency", 256'(lat4), 256'd17);
    checkOutput("empty_r8_latency", 256'(lat8), 256'd9);
    checkOutput("empty_r2_digest", digest2, EMPTY_DIGEST);
    checkOutput("empty_r4_digest", digest4, EMPTY_DIGEST);
    checkOutput("empty_r8_digest", digest8, EMPTY_DIGEST);

    // Two-block message, second start issued in the done cycle.
    runBlock("two_blk1", 1'b1, two_b1, mid1);
    runBlock("two_blk2", 1'b0, two_b2, TWO_DIGEST);

    // Start pulsed mid-ROUND must be ignored.
    applyStimulus("busy", 1'b1, abc_blk);
    repeat (10) @(posedge clk);
    #1;
    block = empty_blk; first = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone("busy", lat);
    checkOutput("busy_latency", 256'(lat), 256'd54);
    checkOutput("busy_digest", digest1, ABC_DIGEST);

    // Reset at round 30: immediate idle with cleared digest, then a clean rerun.
    applyStimulus("rst_mid", 1'b1, abc_blk);
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_ready", 256'(ready1), 256'd1);
    checkOutput("rst_mid_done", 256'(done1), 256'd0);
    checkOutput("rst_mid_digest", digest1, 256'd0);
    #1;
    rst = 1'b0;
    runBlock("rst_abc", 1'b1, abc_blk, ABC_DIGEST);

    // After reset, first=0 chains from an all-zero digest.
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rst2_digest", digest1, 256'd0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) rnd_blk[511 - 32*i -: 32] = $urandom();
    exp_digest = refCompress(256'd0, rnd_blk);
    runBlock("zero_chain", 1'b0, rnd_blk, exp_digest);

    // Random blocks with random first, chained back-to-back.
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 16; i++) rnd_blk[511 - 32*i -: 32] = $urandom();
      rf = 1'($urandom_range(0, 1));
      exp_digest = refCompress(rf ? IV : exp_digest, rnd_blk);
      runBlock($sformatf("rand%0d", n), rf, rnd_blk, exp_digest);
    end

`ifdef SHA256_MIDSTATE_EN
    // Midstate overrides first: second header block from a precomputed midstate.
    midstate = mid1;
    mid_sel  = 1'b1;
    runBlock("midstate", 1'b1, two_b2, TWO_DIGEST);
    mid_sel  = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
